// File: rtl/video_stream_mux.sv
// Frame-aligned Avalon-ST video input selector with an Avalon-MM control slave.
// One sink channel is forwarded through a small FIFO; channel changes take effect only between frames.
module video_stream_mux #(
  parameter int NUM_CH     = 2,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     chipselect,
  input  logic [1:0]               address,
  input  logic                     write,
  input  logic [31:0]              writedata,
  input  logic                     read,
  output logic [31:0]              readdata,
  input  logic [NUM_CH-1:0]        valid_in,
  output logic [NUM_CH-1:0]        ready_out,
  input  logic [NUM_CH*DATA_W-1:0] data_in,
  input  logic [NUM_CH-1:0]        startofpacket_in,
  input  logic [NUM_CH-1:0]        endofpacket_in,
  output logic                     valid_out,
  input  logic                     ready_in,
  output logic [DATA_W-1:0]        data_out,
  output logic                     startofpacket_out,
  output logic                     endofpacket_out
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = DATA_W + 2;
  localparam logic [3:0]     NUM_CH_L = 4'(NUM_CH);
  localparam logic [PTR_W:0] DEPTH_L  = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic {IDLE = 1'b0, PASS = 1'b1} state_t;

  state_t              state_r, state_next_s;
  logic [CH_W-1:0]     active_r;
  logic [3:0]          sel_r;
  logic                drop_r, enable_r, bad_sel_r, run_r;
  logic [31:0]         frame_cnt_r, readdata_r;
  logic [ENT_W-1:0]    mem_r [FIFO_DEPTH];
  logic [PTR_W:0]      wr_ptr_r, rd_ptr_r, count_s;
  logic                full_s, empty_s, push_s, pop_s, acc_s, load_s, sel_ready_s;
  logic                valid_a_s, sop_a_s, eop_a_s, wr_s, rd_s, pending_s;
  logic [DATA_W-1:0]   data_a_s;
  logic [ENT_W-1:0]    head_s;
  logic [3:0]          active_ext_s;

  assign count_s      = wr_ptr_r - rd_ptr_r;
  assign full_s       = (count_s == DEPTH_L);
  assign empty_s      = (count_s == {(PTR_W + 1){1'b0}});
  assign valid_a_s    = valid_in[active_r];
  assign sop_a_s      = startofpacket_in[active_r];
  assign eop_a_s      = endofpacket_in[active_r];
  assign data_a_s     = data_in[active_r*DATA_W +: DATA_W];
  assign head_s       = mem_r[rd_ptr_r[PTR_W-1:0]];
  assign acc_s        = valid_a_s & sel_ready_s;
  assign pop_s        = ~empty_s & ready_in;
  assign wr_s         = chipselect & write;
  assign rd_s         = chipselect & read;
  assign active_ext_s = 4'(active_r);
  assign pending_s    = (sel_r != active_ext_s);
  assign readdata     = readdata_r;

  // Ready of the selected channel; run_r keeps every ready low until the first clock after reset
  always_comb begin
    sel_ready_s = 1'b0;
    if (!run_r) begin
      sel_ready_s = 1'b0;
    end else if (state_r == PASS) begin
      sel_ready_s = ~full_s;
    end else begin
      sel_ready_s = enable_r & ~full_s;
    end
  end

  // Per-channel ready: selected channel follows the FSM, others accept-and-drop or stall
  always_comb begin
    ready_out = {NUM_CH{1'b0}};
    for (int k = 0; k < NUM_CH; k++) begin
      if (CH_W'(k) == active_r) begin
        ready_out[k] = sel_ready_s;
      end else begin
        ready_out[k] = drop_r & run_r;
      end
    end
  end

  // Frame FSM next state and push decision; beats outside a frame are discarded until an SOP
  always_comb begin
    state_next_s = state_r;
    push_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (acc_s && sop_a_s && enable_r) begin
          push_s       = 1'b1;
          state_next_s = eop_a_s ? IDLE : PASS;
        end else begin
          state_next_s = IDLE;
        end
      end
      PASS: begin
        if (acc_s) begin
          push_s       = 1'b1;
          state_next_s = eop_a_s ? IDLE : PASS;
        end else begin
          state_next_s = PASS;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  assign load_s = (state_next_s == IDLE);

  // FSM state, active channel (reloaded whenever the next cycle is between frames)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= IDLE;
      active_r <= {CH_W{1'b0}};
      run_r    <= 1'b0;
    end else begin
      state_r <= state_next_s;
      run_r   <= 1'b1;
      if (load_s) active_r <= sel_r[CH_W-1:0];
    end
  end

  // Control register and bad_sel sticky flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_r     <= 4'd0;
      drop_r    <= 1'b0;
      enable_r  <= 1'b1;
      bad_sel_r <= 1'b0;
    end else if (wr_s && address == 2'd0) begin
      drop_r   <= writedata[8];
      enable_r <= writedata[31];
      if (writedata[3:0] < NUM_CH_L) sel_r <= writedata[3:0];
      else bad_sel_r <= 1'b1;
    end else if (wr_s && address == 2'd1) begin
      bad_sel_r <= 1'b0;
    end
  end

  // Frame counter: counts EOP beats leaving the source; a CSR write takes priority
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt_r <= 32'd0;
    end else if (wr_s && address == 2'd2) begin
      frame_cnt_r <= 32'd0;
    end else if (pop_s && head_s[DATA_W]) begin
      frame_cnt_r <= frame_cnt_r + 32'd1;
    end
  end

  // FIFO pointers; one spare bit distinguishes full from empty
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {(PTR_W + 1){1'b0}};
      rd_ptr_r <= {(PTR_W + 1){1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
    end
  end

  // FIFO storage {sop, eop, data}; contents are don't-care while empty
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r[PTR_W-1:0]] <= {sop_a_s, eop_a_s, data_a_s};
  end

  // Registered read port, latency 1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      readdata_r <= 32'd0;
    end else if (rd_s) begin
      case (address)
        2'd0:    readdata_r <= {enable_r, 22'd0, drop_r, 4'd0, sel_r};
        2'd1:    readdata_r <= {21'd0, bad_sel_r, pending_s, (state_r == PASS), 4'd0, active_ext_s};
        2'd2:    readdata_r <= frame_cnt_r;
        2'd3:    readdata_r <= 32'(count_s);
        default: readdata_r <= 32'd0;
      endcase
    end
  end

  // Source port shows the FIFO head, forced to zero while empty
  always_comb begin
    valid_out = ~empty_s;
    if (empty_s) begin
      data_out          = {DATA_W{1'b0}};
      startofpacket_out = 1'b0;
      endofpacket_out   = 1'b0;
    end else begin
      data_out          = head_s[DATA_W-1:0];
      startofpacket_out = head_s[DATA_W+1];
      endofpacket_out   = head_s[DATA_W];
    end
  end

endmodule

// File: tb/tb_video_stream_mux.sv
// Randomised bench for video_stream_mux: a queue-based frame model predicts ready, source beats and CSR reads.
module tb_video_stream_mux;
  localparam int NCH = 3;
  localparam int DW  = 16;
  localparam int FD  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              chipselect = 1'b0, write = 1'b0, read = 1'b0, ready_in = 1'b1;
  logic [1:0]        address = 2'd0;
  logic [31:0]       writedata = 32'd0, readdata;
  logic [NCH-1:0]    valid_in = '0, ready_out, startofpacket_in = '0, endofpacket_in = '0;
  logic [NCH*DW-1:0] data_in = '0;
  logic              valid_out, startofpacket_out, endofpacket_out;
  logic [DW-1:0]     data_out;

  video_stream_mux #(.NUM_CH(NCH), .DATA_W(DW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .address(address), .write(write),
    .writedata(writedata), .read(read), .readdata(readdata), .valid_in(valid_in),
    .ready_out(ready_out), .data_in(data_in), .startofpacket_in(startofpacket_in),
    .endofpacket_in(endofpacket_in), .valid_out(valid_out), .ready_in(ready_in),
    .data_out(data_out), .startofpacket_out(startofpacket_out), .endofpacket_out(endofpacket_out));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  int          m_act;
  bit          m_inf, m_drop, m_en, m_bad, m_run;
  logic [3:0]  m_sel;
  logic [31:0] m_cnt, m_rd;
  logic [17:0] m_q[$];
  bit          acc[NCH];

  // per-channel traffic sources
  int          pos[NCH], len[NCH];
  bit          vld[NCH], src_on[NCH];
  logic [DW-1:0] dat[NCH];
  int          rate = 100;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: observed timeout expected event", tag);
  endtask

  task automatic model_reset();
    m_act = 0; m_inf = 0; m_drop = 0; m_en = 1; m_bad = 0; m_run = 0;
    m_sel = 4'd0; m_cnt = 32'd0; m_rd = 32'd0;
    m_q.delete();
  endtask

  task automatic drive_src();
    for (int k = 0; k < NCH; k++) begin
      valid_in[k]          = vld[k];
      data_in[k*DW +: DW]  = dat[k];
      startofpacket_in[k]  = (pos[k] == 0);
      endofpacket_in[k]    = (pos[k] == len[k] - 1);
    end
  endtask

  task automatic advance_src();
    for (int k = 0; k < NCH; k++) begin
      if (acc[k]) begin
        pos[k]++;
        if (pos[k] >= len[k]) begin
          pos[k] = 0;
          len[k] = $urandom_range(1, 6);
        end
        dat[k] = DW'($urandom);
        vld[k] = 1'b0;
      end
      if (!vld[k]) vld[k] = src_on[k] && ($urandom_range(1, 100) <= rate);
    end
    drive_src();
  endtask

  // compare all outputs before the edge, then advance the model by one clock
  task automatic step();
    logic [NCH-1:0] er;
    logic [17:0]    head;
    bit             ev, pop, push, inf_n;
    logic [3:0]     old_sel;
    @(negedge clk);
    if (!reset) model_reset();
    for (int k = 0; k < NCH; k++) begin
      if (!m_run)        er[k] = 1'b0;
      else if (k == m_act) er[k] = (m_q.size() < FD) && (m_inf || m_en);
      else               er[k] = m_drop;
    end
    ev   = (m_q.size() > 0);
    head = ev ? m_q[0] : 18'd0;
    chk("ready_out", 32'(ready_out), 32'(er));
    chk("valid_out", 32'(valid_out), 32'(ev));
    chk("data_out", 32'(data_out), 32'(head[15:0]));
    chk("sop_out", 32'(startofpacket_out), 32'(head[17]));
    chk("eop_out", 32'(endofpacket_out), 32'(head[16]));
    chk("readdata", readdata, m_rd);
    for (int k = 0; k < NCH; k++) acc[k] = reset && valid_in[k] && er[k];
    if (reset) begin
      pop = ev && ready_in;
      push = 1'b0;
      inf_n = m_inf;
      old_sel = m_sel;
      if (chipselect && read) begin
        case (address)
          2'd0:    m_rd = {m_en, 22'd0, m_drop, 4'd0, m_sel};
          2'd1:    m_rd = {21'd0, m_bad, (m_sel != 4'(m_act)), m_inf, 4'd0, 4'(m_act)};
          2'd2:    m_rd = m_cnt;
          default: m_rd = 32'(m_q.size());
        endcase
      end
      if (acc[m_act] && (m_inf || (startofpacket_in[m_act] && m_en))) begin
        push  = 1'b1;
        inf_n = !endofpacket_in[m_act];
      end
      if (pop && head[16]) m_cnt = m_cnt + 32'd1;
      if (chipselect && write) begin
        if (address == 2'd0) begin
          m_drop = writedata[8];
          m_en   = writedata[31];
          if (writedata[3:0] < NCH) m_sel = writedata[3:0];
          else m_bad = 1'b1;
        end else if (address == 2'd1) m_bad = 1'b0;
        else if (address == 2'd2) m_cnt = 32'd0;
      end
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back({startofpacket_in[m_act], endofpacket_in[m_act], data_in[m_act*DW +: DW]});
      m_inf = inf_n;
      if (!inf_n) m_act = int'(old_sel);
      m_run = 1'b1;
    end
    @(posedge clk);
    #1;
    advance_src();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    step();
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic csr_read(input logic [1:0] a);
    chipselect = 1'b1; read = 1'b1; address = a;
    step();
    chipselect = 1'b0; read = 1'b0;
  endtask

  initial begin
    int n;
    model_reset();
    for (int k = 0; k < NCH; k++) begin
      pos[k] = 0; len[k] = $urandom_range(1, 6); vld[k] = 0; src_on[k] = 0; dat[k] = DW'($urandom);
    end
    len[0] = 4;
    drive_src();

    // reset state
    steps(3);
    chk("rst_valid_out", 32'(valid_out), 32'd0);
    chk("rst_ready_out", 32'(ready_out), 32'd0);
    #1 reset = 1'b1;
    steps(2);
    csr_read(2'd0);
    chk("ctrl_reset_value", readdata, 32'h8000_0000);

    // channel 0 alone at full throughput
    src_on[0] = 1;
    steps(14);
    csr_read(2'd2);
    csr_read(2'd3);

    // switch to channel 1 while channel 0 is mid-frame; channel 1 starts mid-frame
    pos[1] = 2; len[1] = 5; src_on[1] = 1;
    n = 0;
    while (!(pos[0] == 2 && m_inf && m_act == 0) && n < 60) begin step(); n++; end
    if (n >= 60) timeout("wait_beat2");
    csr_write(2'd0, 32'h8000_0001);
    csr_read(2'd1);
    chk("switch_pending", 32'(readdata[9]), 32'd1);
    steps(30);

    // downstream stall longer than the FIFO
    ready_in = 1'b0;
    steps(10);
    ready_in = 1'b1;
    steps(10);

    // unselected channel stall vs drop
    csr_write(2'd0, 32'h8000_0000);
    src_on[2] = 1;
    steps(20);
    csr_write(2'd0, 32'h8000_0100);
    for (int i = 0; i < 20; i++) begin ready_in = 1'($urandom); step(); end
    ready_in = 1'b1;

    // out-of-range select
    csr_write(2'd0, 32'h8000_0003);
    csr_read(2'd1);
    chk("bad_sel_set", 32'(readdata[10]), 32'd1);
    csr_read(2'd0);
    chk("sel_unchanged", 32'(readdata[3:0]), 32'd0);
    csr_write(2'd1, 32'd0);
    csr_read(2'd1);
    chk("bad_sel_clear", 32'(readdata[10]), 32'd0);

    // disable: current frame completes, then the input stalls
    csr_write(2'd0, 32'h0000_0100);
    steps(20);
    csr_write(2'd0, 32'h8000_0100);

    // random traffic, random backpressure and random CSR activity
    for (int i = 0; i < 500; i++) begin
      rate = $urandom_range(30, 100);
      ready_in = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 24))
        0: csr_write(2'd0, {($urandom_range(0, 7) != 0), 22'd0, 1'($urandom), 4'd0, 4'($urandom_range(0, 3))});
        1: csr_read(2'($urandom_range(0, 3)));
        2: csr_write(2'd2, 32'd0);
        default: step();
      endcase
    end
    csr_write(2'd0, 32'h8000_0000);
    ready_in = 1'b1; rate = 100;

    // reset in the middle of a frame
    n = 0;
    while (!(m_inf && m_q.size() > 0) && n < 100) begin step(); n++; end
    if (n >= 100) timeout("wait_midframe");
    #1 reset = 1'b0;
    step();
    chk("midrst_valid_out", 32'(valid_out), 32'd0);
    chk("midrst_readdata", readdata, 32'd0);
    reset = 1'b1;
    csr_read(2'd3);
    chk("midrst_fifo_level", readdata, 32'd0);
    steps(40);
    csr_read(2'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
